// File: rtl/spi_rx_pkg.sv
// Shared constants and state encoding for the SPI operand receiver.
package spi_rx_pkg;
    localparam int unsigned DEF_FRAME_BITS = 10;
    localparam int unsigned OP_MSB         = 9;
    localparam int unsigned A_MSB          = 7;
    localparam int unsigned B_MSB          = 3;
    localparam int unsigned RESP_BITS      = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall pulses
// derived from the synchronised level.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/spi_operand_rx.sv
// Oversampled SPI mode-0 slave: receives op/A/B, commits them atomically at
// chip-select release and returns the previous ALU result and flags on MISO.
module spi_operand_rx
    import spi_rx_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  A_RST       = 4'b0001,
    parameter logic [3:0]  B_RST       = 4'b0011
) (
    input  logic       SLCK,
    input  logic       RST,
    input  logic       CS,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [3:0] result,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    input  logic       C,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [1:0] op,
    output logic       op_valid,
    output logic       frame_err
);
    localparam int unsigned     CW       = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0]   CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0]   CNT_OVR  = CW'(FRAME_BITS + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(SLCK), .rst(RST), .din(SCK),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(SLCK), .rst(RST), .din(CS),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(SLCK), .rst(RST), .din(MOSI),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused = &{1'b0, sck_lvl, mosi_rise, mosi_fall};

    state_t                 state, state_nxt;
    logic [FRAME_BITS-1:0]  sr;
    logic [RESP_BITS-1:0]   resp;
    logic [CW-1:0]          cnt;
    logic                   cs_late;
    logic                   start;

    // A CS fall seen during COMMIT is remembered so IDLE can still start the frame.
    assign start = cs_fall | cs_late;

    always_ff @(posedge SLCK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)   state_nxt = SHIFT;
            SHIFT:   if (cs_rise) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SLCK or posedge RST) begin
        if (RST) begin
            A         <= A_RST;
            B         <= B_RST;
            op        <= 2'b00;
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
            sr        <= '0;
            resp      <= '0;
            cnt       <= '0;
            cs_late   <= 1'b0;
        end else begin
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
            cs_late   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        resp <= {result, N, V, Z, C};
                        sr   <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        sr <= {sr[FRAME_BITS-2:0], mosi_lvl};
                        if (cnt != CNT_OVR) cnt <= cnt + 1'b1;
                    end
                    if (sck_fall) resp <= {resp[RESP_BITS-2:0], 1'b0};
                end
                COMMIT: begin
                    cs_late <= ~cs_lvl;
                    if (cnt == CNT_FULL) begin
                        op       <= sr[OP_MSB -: 2];
                        A        <= sr[A_MSB -: 4];
                        B        <= sr[B_MSB -: 4];
                        op_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign MISO = (state == SHIFT) & resp[RESP_BITS-1];
endmodule

// File: tb/tb_spi_operand_rx.sv
// Directed bench for spi_operand_rx with a frame-level scoreboard model.
module tb_spi_operand_rx;
    logic       SLCK = 1'b0;
    logic       RST, CS, SCK, MOSI, MISO;
    logic [3:0] result, A, B;
    logic       N, V, Z, C;
    logic [1:0] op;
    logic       op_valid, frame_err;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;

    typedef struct {
        bit         commit;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;
    exp_t q[$];

    logic [1:0] m_op;
    logic [3:0] m_a, m_b;

    spi_operand_rx #(
        .FRAME_BITS(10), .SYNC_STAGES(2), .A_RST(4'b0001), .B_RST(4'b0011)
    ) dut (
        .SLCK(SLCK), .RST(RST), .CS(CS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .result(result), .N(N), .V(V), .Z(Z), .C(C),
        .A(A), .B(B), .op(op), .op_valid(op_valid), .frame_err(frame_err)
    );

    always #5 SLCK = ~SLCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each pulse must match the oldest expected frame outcome.
    always @(negedge SLCK) begin
        if (RST) begin
            m_op = 2'b00; m_a = 4'b0001; m_b = 4'b0011;
        end else begin
            if (op_valid === 1'b1 || frame_err === 1'b1) begin
                if (op_valid === 1'b1) n_valid++;
                if (frame_err === 1'b1) n_err++;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: got op_valid=%b frame_err=%b want none at %0t",
                             op_valid, frame_err, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_kind", {op_valid, frame_err}, e.commit ? 2'b10 : 2'b01);
                    if (e.commit) begin
                        m_op = e.op; m_a = e.a; m_b = e.b;
                    end
                end
            end
            chk("op_model", op, m_op);
            chk("a_model", A, m_a);
            chk("b_model", B, m_b);
        end
    end

    // Master side: MISO is sampled just before each SCK rise, as mode 0 requires.
    task automatic clock_bits(input logic [15:0] bits, input int n, input logic [7:0] resp);
        CS = 1'b0;
        for (int i = 0; i < n; i++) begin
            MOSI = bits[n-1-i];
            #40;
            chk($sformatf("miso_bit%0d", i), MISO, (i < 8) ? resp[7-i] : 1'b0);
            SCK = 1'b1;
            #40;
            SCK = 1'b0;
        end
        MOSI = 1'b0;
        #40;
    endtask

    task automatic expect_end(input logic [15:0] bits, input int n);
        exp_t e;
        e.commit = (n == 10);
        e.op = 2'((bits / 256) % 4);
        e.a  = 4'((bits / 16) % 16);
        e.b  = 4'(bits % 16);
        q.push_back(e);
    endtask

    task automatic run_frame(input logic [15:0] bits, input int n);
        clock_bits(bits, n, {result, N, V, Z, C});
        expect_end(bits, n);
        CS = 1'b1;
        #100;
        chk("commit_pending", q.size(), 0);
        chk("miso_idle", MISO, 1'b0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        result = 4'b0000; {N, V, Z, C} = 4'b0000;
        #22 RST = 1'b0;
        #40;
        chk("rst_a", A, 4'b0001);
        chk("rst_b", B, 4'b0011);
        chk("rst_op", op, 2'b00);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_miso", MISO, 1'b0);

        // Full frame; response 1010_1001 returns 1,0,1,0,1,0,0,1,0,0.
        result = 4'b1010; {N, V, Z, C} = 4'b1001;
        run_frame(16'b10_0110_1001, 10);
        chk("f1_op", op, 2'b10);
        chk("f1_a", A, 4'b0110);
        chk("f1_b", B, 4'b1001);
        chk("f1_nvalid", n_valid, 1);

        // Short and long frames are discarded.
        result = 4'b0101; {N, V, Z, C} = 4'b0110;
        run_frame(16'b1_0110_0110, 9);
        run_frame(16'hABC, 12);
        chk("err_nerr", n_err, 2);
        chk("err_nvalid", n_valid, 1);
        chk("err_op", op, 2'b10);
        chk("err_a", A, 4'b0110);
        chk("err_b", B, 4'b1001);

        // SCK activity with CS high must do nothing.
        for (int i = 0; i < 3; i++) begin
            MOSI = 1'b1; SCK = 1'b1; #40; SCK = 1'b0; #40;
        end
        MOSI = 1'b0;
        #100;
        chk("idle_sck_nvalid", n_valid, 1);
        chk("idle_sck_nerr", n_err, 2);
        chk("idle_sck_miso", MISO, 1'b0);

        // CS glitch with no SCK edges.
        expect_end(16'h0, 0);
        CS = 1'b0; #30; CS = 1'b1;
        #100;
        chk("glitch_pending", q.size(), 0);
        chk("glitch_nerr", n_err, 3);
        chk("glitch_a", A, 4'b0110);

        // Back-to-back frames: CS high for one SLCK period between them.
        result = 4'b1100; {N, V, Z, C} = 4'b0011;
        clock_bits(16'b11_0011_1100, 10, {result, N, V, Z, C});
        expect_end(16'b11_0011_1100, 10);
        CS = 1'b1; #10;
        clock_bits(16'b00_1010_0101, 10, {result, N, V, Z, C});
        expect_end(16'b00_1010_0101, 10);
        CS = 1'b1;
        #100;
        chk("b2b_pending", q.size(), 0);
        chk("b2b_nvalid", n_valid, 3);
        chk("b2b_op", op, 2'b00);
        chk("b2b_a", A, 4'b1010);
        chk("b2b_b", B, 4'b0101);

        // Reset after five bits aborts the frame silently.
        clock_bits(16'b11_1010_1010, 5, {result, N, V, Z, C});
        RST = 1'b1;
        #1;
        chk("midrst_a", A, 4'b0001);
        chk("midrst_b", B, 4'b0011);
        chk("midrst_op", op, 2'b00);
        chk("midrst_miso", MISO, 1'b0);
        CS = 1'b1;
        #29 RST = 1'b0;
        #100;
        chk("midrst_nvalid", n_valid, 3);
        chk("midrst_nerr", n_err, 3);
        chk("midrst_a_hold", A, 4'b0001);

        run_frame(16'b01_1111_0000, 10);
        chk("f2_op", op, 2'b01);
        chk("f2_a", A, 4'b1111);
        chk("f2_b", B, 4'b0000);
        chk("final_nvalid", n_valid, 4);
        chk("final_nerr", n_err, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
